// File: rtl/cycle_sequencer.sv
// Machine-cycle T-state sequencer: steps T1/T1I/T2/WAIT/T3/T4/T5/STOPPED,
// selects the cycle type, and handles Ready waits, HLT and interrupt acknowledge.
//
//  state   | meaning
//  T1      | cycle start, address low out
//  T1I     | cycle start of interrupt-acknowledge fetch
//  T2      | address high / cycle type out, Ready checked at end
//  WAIT    | Ready low, repeats until Ready
//  T3      | data transfer, Decoder info sampled at end
//  T4      | optional internal state
//  T5      | optional internal state
//  STOPPED | halted (also after reset), leaves only on an interrupt
module cycle_sequencer #(
  parameter int STATE_CLKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       intr,
  input  logic [1:0] last_state,
  input  logic       last_cycle,
  input  logic [1:0] next_cycle,
  input  logic       halt,
  output logic [2:0] state,
  output logic [1:0] cycle,
  output logic       Sync,
  output logic       step,
  output logic       intr_ack,
  output logic       stopped
);

  localparam int PH_W = (STATE_CLKS > 2) ? $clog2(STATE_CLKS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STATE_CLKS - 1);
  localparam logic [PH_W-1:0] PH_SYNC = PH_W'(STATE_CLKS / 2);

  typedef enum logic [2:0] {
    ST_T1      = 3'b010,
    ST_T1I     = 3'b011,
    ST_T2      = 3'b001,
    ST_WAIT    = 3'b000,
    ST_T3      = 3'b100,
    ST_STOPPED = 3'b110,
    ST_T4      = 3'b111,
    ST_T5      = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    CY_PCI = 2'b00,
    CY_PCR = 2'b10,
    CY_PCC = 2'b01,
    CY_PCW = 2'b11
  } cycle_t;

  state_t          state_q, state_d;
  cycle_t          cycle_q, cycle_d;
  logic [PH_W-1:0] ph_q;
  logic            step_q;
  logic            ack_q;
  logic            pend_q;
  logic            intr_q;
  logic            five_h;
  logic            lc_h;
  logic [1:0]      nc_h;

  logic            end_st;
  logic            intr_edge;
  logic            taken;
  logic            lc_eff;
  logic [1:0]      nc_eff;
  logic            enter_t1i;
  logic            enter_t1;

  assign end_st    = (ph_q == PH_LAST);
  assign intr_edge = intr & ~intr_q;
  assign taken     = pend_q | intr_edge;
  // At end of T3 the live Decoder inputs are the sampled values
  assign lc_eff    = (state_q == ST_T3) ? last_cycle : lc_h;
  assign nc_eff    = (state_q == ST_T3) ? next_cycle : nc_h;
  assign enter_t1i = end_st & (state_d == ST_T1I);
  assign enter_t1  = end_st & (state_d == ST_T1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      cycle_q <= CY_PCI;
      ph_q    <= '0;
      step_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
      five_h  <= 1'b0;
      lc_h    <= 1'b0;
      nc_h    <= 2'b00;
    end else begin
      intr_q <= intr;
      step_q <= end_st;
      if (end_st) begin
        ph_q    <= '0;
        state_q <= state_d;
        cycle_q <= cycle_d;
      end else begin
        ph_q <= ph_q + PH_W'(1);
      end
      if (end_st && state_q == ST_T3) begin
        five_h <= last_state[1];
        lc_h   <= last_cycle;
        nc_h   <= next_cycle;
      end
      // Entering T1I swallows both the pending request and a same-clk edge
      if (enter_t1i)
        pend_q <= 1'b0;
      else if (intr_edge)
        pend_q <= 1'b1;
      if (enter_t1i)
        ack_q <= 1'b1;
      else if (enter_t1)
        ack_q <= 1'b0;
    end
  end

  always_comb begin
    logic cyc_end;
    state_d = state_q;
    cycle_d = cycle_q;
    cyc_end = 1'b0;
    unique case (state_q)
      ST_T1, ST_T1I: state_d = ST_T2;
      ST_T2, ST_WAIT: state_d = ready ? ST_T3 : ST_WAIT;
      ST_T3: begin
        if (halt)
          state_d = ST_STOPPED;
        else if (last_state != 2'b00)
          state_d = ST_T4;
        else
          cyc_end = 1'b1;
      end
      ST_T4: begin
        if (five_h)
          state_d = ST_T5;
        else
          cyc_end = 1'b1;
      end
      ST_T5: cyc_end = 1'b1;
      ST_STOPPED: begin
        if (taken) begin
          state_d = ST_T1I;
          cycle_d = CY_PCI;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    if (cyc_end) begin
      if (!lc_eff) begin
        state_d = ST_T1;
        cycle_d = cycle_t'(nc_eff);
      end else begin
        state_d = taken ? ST_T1I : ST_T1;
        cycle_d = CY_PCI;
      end
    end
  end

  always_comb begin
    state    = state_q;
    cycle    = cycle_q;
    Sync     = (ph_q < PH_SYNC);
    step     = step_q;
    intr_ack = ack_q;
    stopped  = (state_q == ST_STOPPED);
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed and random machine cycles checked against
// a per-cycle expected state list built from the sequencing rules.
module tb_cycle_sequencer;

  localparam int SC = 2;

  localparam logic [2:0] S_T1   = 3'b010;
  localparam logic [2:0] S_T1I  = 3'b011;
  localparam logic [2:0] S_T2   = 3'b001;
  localparam logic [2:0] S_WAIT = 3'b000;
  localparam logic [2:0] S_T3   = 3'b100;
  localparam logic [2:0] S_STOP = 3'b110;
  localparam logic [2:0] S_T4   = 3'b111;
  localparam logic [2:0] S_T5   = 3'b101;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       intr;
  logic [1:0] last_state;
  logic       last_cycle;
  logic [1:0] next_cycle;
  logic       halt;
  logic [2:0] state;
  logic [1:0] cycle;
  logic       Sync;
  logic       step;
  logic       intr_ack;
  logic       stopped;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] m_cyc;
  bit         m_ack;
  bit         m_pend;
  bit         m_prev;

  always #5 clk = ~clk;

  cycle_sequencer #(.STATE_CLKS(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .intr       (intr),
    .last_state (last_state),
    .last_cycle (last_cycle),
    .next_cycle (next_cycle),
    .halt       (halt),
    .state      (state),
    .cycle      (cycle),
    .Sync       (Sync),
    .step       (step),
    .intr_ack   (intr_ack),
    .stopped    (stopped)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_clk(input logic [2:0] es, input int p, input bit exp_step, input string where);
    chk({where, "/state"},    8'(state),    8'(es));
    chk({where, "/Sync"},     8'(Sync),     8'(p < SC / 2));
    chk({where, "/step"},     8'(step),     8'(exp_step));
    chk({where, "/cycle"},    8'(cycle),    8'(m_cyc));
    chk({where, "/intr_ack"}, 8'(intr_ack), 8'(m_ack));
    chk({where, "/stopped"},  8'(stopped),  8'(es == S_STOP));
  endtask

  task automatic drive_intr(input bit v);
    intr = v;
    if (v && !m_prev) m_pend = 1'b1;
    m_prev = v;
  endtask

  task automatic rand_decoder();
    last_state = 2'($urandom_range(0, 3));
    last_cycle = 1'($urandom_range(0, 1));
    next_cycle = 2'($urandom_range(0, 3));
    halt       = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One machine cycle; intr_at is the clk index (within this cycle) at which intr rises.
  task automatic run_cycle(input logic [2:0] first_st, input logic [1:0] ls, input bit lc,
                           input logic [1:0] nc, input bit hlt, input int nwait,
                           input int intr_at, output logic [2:0] next_st);
    logic [2:0] seq[$];
    int idx = 0;
    seq.push_back(first_st);
    seq.push_back(S_T2);
    repeat (nwait) seq.push_back(S_WAIT);
    seq.push_back(S_T3);
    if (!hlt && ls != 2'b00) seq.push_back(S_T4);
    if (!hlt && ls[1]) seq.push_back(S_T5);
    foreach (seq[i]) begin
      for (int p = 0; p < SC; p++) begin
        check_clk(seq[i], p, p == 0, "cyc");
        ready = 1'($urandom_range(0, 1));
        if ((seq[i] == S_T2 || seq[i] == S_WAIT) && p == SC - 1)
          ready = (seq[i+1] == S_T3);
        if (seq[i] == S_T3 && p == SC - 1) begin
          last_state = ls;
          last_cycle = lc;
          next_cycle = nc;
          halt       = hlt;
        end else begin
          rand_decoder();
        end
        drive_intr(idx == intr_at);
        idx++;
        tick();
      end
    end
    if (hlt) begin
      next_st = S_STOP;
    end else if (!lc) begin
      next_st = S_T1;
      m_cyc   = nc;
      m_ack   = 1'b0;
    end else if (m_pend) begin
      next_st = S_T1I;
      m_pend  = 1'b0;
      m_cyc   = 2'b00;
      m_ack   = 1'b1;
    end else begin
      next_st = S_T1;
      m_cyc   = 2'b00;
      m_ack   = 1'b0;
    end
  endtask

  // Sit in STOPPED; intr rises at clk index n_intr; exits into T1I at the next end of state.
  task automatic run_stopped(input int n_intr, input bit after_rst);
    int  idx  = 0;
    bit  done = 1'b0;
    while (!done) begin
      int p = idx % SC;
      check_clk(S_STOP, p, (p == 0) && !(after_rst && idx == 0), "stop");
      ready = 1'($urandom_range(0, 1));
      rand_decoder();
      drive_intr(idx == n_intr);
      if (p == SC - 1 && m_pend) begin
        done   = 1'b1;
        m_pend = 1'b0;
        m_cyc  = 2'b00;
        m_ack  = 1'b1;
      end
      idx++;
      tick();
    end
  endtask

  initial begin
    logic [2:0] nxt;
    rst = 1'b1; ready = 1'b0; intr = 1'b0;
    last_state = 2'b00; last_cycle = 1'b0; next_cycle = 2'b00; halt = 1'b0;
    m_cyc = 2'b00; m_ack = 1'b0; m_pend = 1'b0; m_prev = 1'b0;

    #12;
    check_clk(S_STOP, 0, 1'b0, "reset");
    @(negedge clk);
    rst = 1'b0;

    run_stopped(21, 1'b1);
    run_cycle(S_T1I, 2'b00, 1'b0, 2'b10, 1'b0, 0, -1, nxt);
    run_cycle(nxt,   2'b00, 1'b1, 2'b00, 1'b0, 3, -1, nxt);
    run_cycle(nxt,   2'b00, 1'b1, 2'b00, 1'b0, 0, -1, nxt);
    run_cycle(nxt,   2'b10, 1'b0, 2'b11, 1'b0, 0, -1, nxt);
    run_cycle(nxt,   2'b00, 1'b1, 2'b00, 1'b0, 0, 3 * SC - 1, nxt);
    run_cycle(nxt,   2'b00, 1'b1, 2'b00, 1'b0, 0, -1, nxt);
    run_cycle(nxt,   2'b00, 1'b1, 2'b00, 1'b1, 1, -1, nxt);
    run_stopped(1, 1'b0);
    run_cycle(S_T1I, 2'b11, 1'b1, 2'b00, 1'b0, 0, -1, nxt);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] ls, nc;
      bit         lc, hlt;
      int         nw, ia;
      ls  = 2'($urandom_range(0, 3));
      nc  = 2'($urandom_range(0, 3));
      lc  = 1'($urandom_range(0, 1));
      hlt = ($urandom_range(0, 7) == 0);
      nw  = $urandom_range(0, 3);
      ia  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      run_cycle(nxt, ls, lc, nc, hlt, nw, ia, nxt);
      if (nxt == S_STOP) begin
        run_stopped($urandom_range(0, 5), 1'b0);
        nxt = S_T1I;
      end
    end

    // Reset asserted mid-WAIT takes effect without a clk edge
    for (int p = 0; p < SC; p++) begin
      check_clk(nxt, p, p == 0, "pre_rst");
      ready = 1'b1; rand_decoder(); drive_intr(1'b0);
      tick();
    end
    for (int p = 0; p < SC; p++) begin
      check_clk(S_T2, p, p == 0, "pre_rst");
      ready = (p == SC - 1) ? 1'b0 : 1'b1; rand_decoder(); drive_intr(1'b0);
      tick();
    end
    check_clk(S_WAIT, 0, 1'b1, "pre_rst");
    rst = 1'b1;
    #1;
    m_cyc = 2'b00; m_ack = 1'b0; m_pend = 1'b0; m_prev = 1'b0;
    check_clk(S_STOP, 0, 1'b0, "rst_wait");
    @(negedge clk);
    rst = 1'b0;
    run_stopped(3, 1'b1);
    run_cycle(S_T1I, 2'b01, 1'b1, 2'b00, 1'b0, 2, -1, nxt);
    check_clk(nxt, 0, 1'b1, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Machine-cycle state sequencer for the 8008 core. It steps the processor through the T-states T1, T1I, T2, WAIT, T3, STOPPED, T4 and T5 and emits `state_t` and `Sync`. It selects the cycle type (PCI/PCR/PCC/PCW) and handles Ready wait-states, HLT, and interrupt acknowledge. It sits between the Decoder, which supplies cycle length and next-cycle information, and the datapath, bus and pad logic, which consume state, cycle and strobes.

## Interface
Parameters:
- `STATE_CLKS`, default 2: `clk` periods per T-state. Legal values are ≥2.

Ports:
- `clk`  in  1  Single system clock; all state changes on posedge.
- `rst`  in  1  Asynchronous, active-high reset.
- `ready`  in  1  Memory/IO ready, already synchronized.
- `intr`  in  1  Interrupt request, already synchronized; rising-edge detected.
- `last_state`  in  2  Decoder: final T-state of the current cycle. 00 = T3, 01 = T4, 10 = T5, 11 is treated as T5.
- `last_cycle`  in  1  Decoder: the current cycle ends the instruction.
- `next_cycle`  in  2  Decoder: `cycle_t` of the following cycle when `last_cycle` = 0.
- `halt`  in  1  Decoder: the current instruction is HLT.
- `state`  out  3  `state_t`. Encodings: T1 = 010, T1I = 011, T2 = 001, WAIT = 000, T3 = 100, STOPPED = 110, T4 = 111, T5 = 101.
- `cycle`  out  2  `cycle_t`. Encodings: PCI = 00, PCR = 10, PCC = 01, PCW = 11.
- `Sync`  out  1  High for the first `STATE_CLKS/2` (floor) clks of every state, low for the rest.
- `step`  out  1  One-clk pulse on the first clk of every state, including repeated WAIT/STOPPED states.
- `intr_ack`  out  1  High throughout the interrupt-acknowledge PCI cycle, from T1I up to the next T1/T1I. The PC logic inhibits increment while it is high.
- `stopped`  out  1  Equals (`state` == STOPPED).

## Operation
- A phase counter `ph` runs 0..`STATE_CLKS`-1 continuously in every state. "End of state" means `ph` = `STATE_CLKS`-1. All transitions occur only at end of state.
- The Decoder inputs `last_state`, `last_cycle`, `next_cycle` and `halt` are sampled once, at end of T3, and held internally until the cycle ends.
- Transitions:
  - T1 or T1I → T2.
  - T2 → T3 if `ready` = 1, else WAIT.
  - WAIT → WAIT while `ready` = 0; → T3 when `ready` = 1.
  - T3 → STOPPED if `halt`. Otherwise → T4 if `last_state` ≠ 00. Otherwise → cycle end.
  - T4 → T5 if `last_state` ≥ 10, else → cycle end.
  - T5 → cycle end.
  - STOPPED → T1I if an interrupt is taken, else → STOPPED.
- Cycle end:
  - If `last_cycle` = 0: → T1, with `cycle` ← held `next_cycle`.
  - If `last_cycle` = 1: → T1I if an interrupt is taken, else → T1; in both cases `cycle` ← PCI.
- Interrupts:
  - A rising edge of `intr` sets `pend`.
  - "Interrupt taken" means (`pend` | rising edge on this clk).
  - Entering T1I clears `pend`, and also consumes any edge arriving on that same clk.
  - Interrupts are never taken mid-instruction. They are taken only at instruction end or from STOPPED.
- `cycle` changes only on entry to T1/T1I. It holds the same value across WAIT, T4 and T5.
- `intr_ack` sets on entry to T1I and clears on the next entry to T1 or T1I.
- Reset values (`rst` high, asynchronous):
  - `state` = STOPPED, `cycle` = PCI.
  - `ph` = 0, `Sync` = 1, `step` = 0.
  - `pend` = 0, `intr_ack` = 0, `stopped` = 1.
  - The edge detector's previous-`intr` register = 0.
- Reset mid-cycle aborts the cycle immediately; held Decoder info is discarded. The first `clk` after release is `ph` = 0 of STOPPED. The core therefore starts only on an interrupt, as the 8008 does.

## Timing
- Each non-waiting state lasts exactly `STATE_CLKS` clks. The new `state` is visible on the clk after end of state.
- `step` asserts on the same clk as the new `state` (`ph` = 0).
- Cycle lengths with `ready` = 1:
  - 3-state cycle: 3·`STATE_CLKS` clks.
  - 4-state cycle: 4·`STATE_CLKS` clks.
  - 5-state cycle: 5·`STATE_CLKS` clks.
- Each WAIT adds `STATE_CLKS` clks. `ready` is examined only at end of T2/WAIT; a glitch at other phases has no effect.
- Interrupt latency from STOPPED: a rising edge at any `ph` gives T1I at the next end of state, i.e. ≤ `STATE_CLKS` clks later.
- `Sync` toggles through WAIT and STOPPED without interruption.

## Test plan
- Reset release with no `intr` → `state` stays 110 and `stopped` = 1 for ≥20 clks. Pulse `intr` → `state` = 011 within 2 clks, then `intr_ack` = 1 and `cycle` = 00.
- 3-state PCI fetch (`last_state` = 00, `last_cycle` = 1, `ready` = 1, `STATE_CLKS` = 2) → sequence 010, 001, 100, 010; each state lasts 2 clks; `Sync` reads 1,0 in each state.
- PCR cycle with `ready` held low for 3 WAIT states → T2 is followed by 000 for 6 clks, then 100. `step` pulses on each WAIT entry. `cycle` stays 10 throughout.
- 5-state instruction (`last_state` = 10, `last_cycle` = 0, `next_cycle` = 11) → T3 is followed by T4, T5, then T1 with `cycle` = 11.
- HLT (`halt` = 1 at T3) → STOPPED. `intr` rising at `ph` = 1 of STOPPED → T1I on the next clk, and `pend` = 0 afterwards.
- `intr` rising coincident with the instruction's last end of state → T1I, exactly one `intr_ack` cycle, and the following instruction starts at T1. Separately, asserting `rst` during WAIT → `state` = 110 with `Sync` = 1 immediately, without waiting for a `clk` edge.
